snake_engine: RTL and testbench



---
 rtl/snake_engine.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_snake_engine.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_engine.sv
// Snake body engine: ring buffer of grid cells, step/collision/growth
// sequencing and a valid/ready pixel stream of body and food cells.
//
// state     | meaning
// ----------|----------------------------------------------------------
// IDLE      | waiting for step (priority) or draw_start
// CALC      | resolve direction, compute new head, wall and food check
// SCAN      | compare new head with one body segment per cycle
// COMMIT    | push new head into the ring, grow if food was eaten
// DRAW_SEG  | stream body cells, head first, row-major inside a cell
// DRAW_FOOD | stream valid food cells in ascending slot order
// DONE      | one-cycle draw_done pulse
module snake_engine #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int GRID_W   = 64,
    parameter int GRID_H   = 48,
    parameter int CELL     = 10,
    parameter int FOOD_N   = 9,
    parameter int CXW      = $clog2(GRID_W),
    parameter int CYW      = $clog2(GRID_H),
    parameter int LW       = $clog2(MAX_LEN + 1),
    parameter int FIW      = (FOOD_N > 1) ? $clog2(FOOD_N) : 1
) (
    input  logic                         draw_clk,
    input  logic                         reset_n,
    input  logic                         step,
    input  logic [1:0]                   direction,
    input  logic [FOOD_N-1:0][CXW-1:0]   food_cx,
    input  logic [FOOD_N-1:0][CYW-1:0]   food_cy,
    input  logic [FOOD_N-1:0]            food_valid,
    input  logic                         draw_start,
    input  logic                         pix_ready,
    output logic                         pix_valid,
    output logic [9:0]                   pix_x,
    output logic [8:0]                   pix_y,
    output logic [1:0]                   pix_kind,
    output logic                         draw_done,
    output logic                         busy,
    output logic                         ate,
    output logic [FIW-1:0]               ate_idx,
    output logic                         game_over,
    output logic [LW-1:0]                length,
    output logic [CXW-1:0]               head_cx,
    output logic [CYW-1:0]               head_cy
);

    localparam int PW = $clog2(MAX_LEN);
    localparam int CW = $clog2(CELL);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_SCAN, S_COMMIT, S_DRAW_SEG, S_DRAW_FOOD, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic [CXW-1:0]  seg_x [MAX_LEN];
    logic [CYW-1:0]  seg_y [MAX_LEN];
    logic [PW-1:0]   head_ptr;
    logic [LW-1:0]   len_q;
    logic [1:0]      cur_dir;
    logic            game_over_q;
    logic [CXW-1:0]  new_cx;
    logic [CYW-1:0]  new_cy;
    logic            grow_q;
    logic [FIW-1:0]  food_idx_q;
    // walk_ptr/walk_left are shared by SCAN and DRAW_SEG: both walk the body
    logic [PW-1:0]   walk_ptr;
    logic [LW-1:0]   walk_left;
    logic [CW-1:0]   sub_x, sub_y;
    logic [FIW-1:0]  food_sel;

    logic [1:0]      rev_dir, eff_dir;
    logic [CXW-1:0]  hx, calc_cx, cell_cx;
    logic [CYW-1:0]  hy, calc_cy, cell_cy;
    logic            wall_hit, food_hit, any_food, more_food;
    logic [FIW-1:0]  food_hit_idx, first_food, next_food;
    logic            scan_match, cell_last, hs;
    logic [PW-1:0]   head_dec, walk_inc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(MAX_LEN - 1) : p - 1'b1;
    endfunction

    assign head_dec  = ptr_dec(head_ptr);
    assign walk_inc  = ptr_inc(walk_ptr);
    assign head_cx   = seg_x[head_ptr];
    assign head_cy   = seg_y[head_ptr];
    assign length    = len_q;
    assign game_over = game_over_q;

    // Direction resolution (reversal ignored), candidate head and wall test
    always_comb begin
        rev_dir  = {~cur_dir[1], cur_dir[0]};
        eff_dir  = (direction == rev_dir) ? cur_dir : direction;
        hx       = seg_x[head_ptr];
        hy       = seg_y[head_ptr];
        calc_cx  = hx;
        calc_cy  = hy;
        wall_hit = 1'b0;
        case (eff_dir)
            2'b00:   begin wall_hit = (hy == '0);                calc_cy = hy - 1'b1; end
            2'b01:   begin wall_hit = (hx == CXW'(GRID_W - 1));  calc_cx = hx + 1'b1; end
            2'b10:   begin wall_hit = (hy == CYW'(GRID_H - 1));  calc_cy = hy + 1'b1; end
            default: begin wall_hit = (hx == '0);                calc_cx = hx - 1'b1; end
        endcase
    end

    // Food lookups; descending loops so the lowest matching slot wins
    always_comb begin
        food_hit     = 1'b0;
        food_hit_idx = '0;
        any_food     = 1'b0;
        first_food   = '0;
        more_food    = 1'b0;
        next_food    = '0;
        for (int i = FOOD_N - 1; i >= 0; i--) begin
            if (food_valid[i] && food_cx[i] == calc_cx && food_cy[i] == calc_cy) begin
                food_hit     = 1'b1;
                food_hit_idx = FIW'(i);
            end
            if (food_valid[i]) begin
                any_food   = 1'b1;
                first_food = FIW'(i);
            end
            if (food_valid[i] && i > int'(food_sel)) begin
                more_food = 1'b1;
                next_food = FIW'(i);
            end
        end
    end

    // Body compare for SCAN and current cell for the pixel stream
    always_comb begin
        scan_match = (seg_x[walk_ptr] == new_cx) && (seg_y[walk_ptr] == new_cy)
                     && !((walk_left == '0) && !grow_q);
        cell_cx    = seg_x[walk_ptr];
        cell_cy    = seg_y[walk_ptr];
        if (state == S_DRAW_FOOD) begin
            cell_cx = food_cx[food_sel];
            cell_cy = food_cy[food_sel];
        end
        cell_last  = (sub_x == CW'(CELL - 1)) && (sub_y == CW'(CELL - 1));
    end

    // Next-state and output decode
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        pix_valid = 1'b0;
        pix_kind  = 2'd0;
        pix_x     = '0;
        pix_y     = '0;
        draw_done = 1'b0;
        ate       = 1'b0;
        ate_idx   = '0;
        if (state == S_DRAW_SEG || state == S_DRAW_FOOD) begin
            pix_valid = 1'b1;
            pix_x     = 10'(cell_cx) * 10'(CELL) + 10'(sub_x);
            pix_y     = 9'(cell_cy) * 9'(CELL) + 9'(sub_y);
            if (state == S_DRAW_FOOD)
                pix_kind = 2'd2;
            else
                pix_kind = (walk_ptr == head_ptr) ? 2'd0 : 2'd1;
        end
        hs = pix_valid & pix_ready;
        case (state)
            S_IDLE: begin
                if (step && !game_over_q) state_nxt = S_CALC;
                else if (draw_start)      state_nxt = S_DRAW_SEG;
            end
            S_CALC:   state_nxt = wall_hit ? S_IDLE : S_SCAN;
            S_SCAN: begin
                if (scan_match)             state_nxt = S_IDLE;
                else if (walk_left == '0)   state_nxt = S_COMMIT;
            end
            S_COMMIT: begin
                ate       = grow_q;
                ate_idx   = grow_q ? food_idx_q : '0;
                state_nxt = S_IDLE;
            end
            S_DRAW_SEG: begin
                if (hs && cell_last && walk_left == '0)
                    state_nxt = any_food ? S_DRAW_FOOD : S_DONE;
            end
            S_DRAW_FOOD: begin
                if (hs && cell_last && !more_food) state_nxt = S_DONE;
            end
            S_DONE: begin
                draw_done = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge draw_clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Body ring, step bookkeeping and stream counters
    always_ff @(posedge draw_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? CXW'(GRID_W / 2 - i) : '0;
                seg_y[i] <= CYW'(GRID_H / 2);
            end
            head_ptr    <= '0;
            len_q       <= LW'(INIT_LEN);
            cur_dir     <= 2'b01;
            game_over_q <= 1'b0;
            new_cx      <= '0;
            new_cy      <= '0;
            grow_q      <= 1'b0;
            food_idx_q  <= '0;
            walk_ptr    <= '0;
            walk_left   <= '0;
            sub_x       <= '0;
            sub_y       <= '0;
            food_sel    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    walk_ptr  <= head_ptr;
                    walk_left <= len_q - 1'b1;
                    sub_x     <= '0;
                    sub_y     <= '0;
                end
                S_CALC: begin
                    cur_dir    <= eff_dir;
                    new_cx     <= calc_cx;
                    new_cy     <= calc_cy;
                    grow_q     <= food_hit;
                    food_idx_q <= food_hit_idx;
                    if (wall_hit) game_over_q <= 1'b1;
                end
                S_SCAN: begin
                    if (scan_match) begin
                        game_over_q <= 1'b1;
                    end else if (walk_left != '0) begin
                        walk_left <= walk_left - 1'b1;
                        walk_ptr  <= walk_inc;
                    end
                end
                S_COMMIT: begin
                    // At saturation the slot written is the old tail, so it advances
                    head_ptr        <= head_dec;
                    seg_x[head_dec] <= new_cx;
                    seg_y[head_dec] <= new_cy;
                    if (grow_q && len_q < LW'(MAX_LEN)) len_q <= len_q + 1'b1;
                end
                S_DRAW_SEG, S_DRAW_FOOD: begin
                    if (hs) begin
                        if (sub_x == CW'(CELL - 1)) begin
                            sub_x <= '0;
                            sub_y <= (sub_y == CW'(CELL - 1)) ? '0 : sub_y + 1'b1;
                        end else begin
                            sub_x <= sub_x + 1'b1;
                        end
                        if (cell_last) begin
                            if (state == S_DRAW_SEG) begin
                                walk_ptr  <= walk_inc;
                                walk_left <= walk_left - 1'b1;
                                if (walk_left == '0) food_sel <= first_food;
                            end else begin
                                food_sel <= next_food;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine against a queue-based game model.
module tb_snake_engine;

    localparam int GW = 64, GH = 48, C = 10, FN = 9, MAXL = 16;

    logic                   draw_clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   step = 1'b0;
    logic [1:0]             direction = 2'b01;
    logic [FN-1:0][5:0]     food_cx;
    logic [FN-1:0][5:0]     food_cy;
    logic [FN-1:0]          food_valid;
    logic                   draw_start = 1'b0;
    logic                   pix_ready = 1'b0;
    logic                   pix_valid;
    logic [9:0]             pix_x;
    logic [8:0]             pix_y;
    logic [1:0]             pix_kind;
    logic                   draw_done, busy, ate, game_over;
    logic [3:0]             ate_idx;
    logic [4:0]             length;
    logic [5:0]             head_cx, head_cy;

    snake_engine dut (
        .draw_clk(draw_clk), .reset_n(reset_n), .step(step), .direction(direction),
        .food_cx(food_cx), .food_cy(food_cy), .food_valid(food_valid),
        .draw_start(draw_start), .pix_ready(pix_ready), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_kind(pix_kind), .draw_done(draw_done),
        .busy(busy), .ate(ate), .ate_idx(ate_idx), .game_over(game_over),
        .length(length), .head_cx(head_cx), .head_cy(head_cy)
    );

    always #5 draw_clk = ~draw_clk;

    int fx [FN];
    int fy [FN];
    bit fv [FN];

    always_comb begin
        for (int i = 0; i < FN; i++) begin
            food_cx[i]    = 6'(fx[i]);
            food_cy[i]    = 6'(fy[i]);
            food_valid[i] = fv[i];
        end
    end

    int checks = 0, errors = 0;
    int mx[$], my[$];
    int m_dir;
    bit m_over;
    bit mon_en = 0;
    int last_bc, last_ac, last_ai;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = {}; my = {};
        for (int i = 0; i < 3; i++) begin
            mx.push_back(GW / 2 - i);
            my.push_back(GH / 2);
        end
        m_dir = 1;
        m_over = 0;
    endtask

    task automatic clear_food();
        for (int i = 0; i < FN; i++) begin fv[i] = 0; fx[i] = 0; fy[i] = 0; end
    endtask

    // Game rules: returns expected busy cycles, ate pulses, eaten slot
    task automatic model_step(input int d, output int eb, output int ea, output int ei);
        int eff, nx, ny, fi, len;
        bit grow;
        eb = 0; ea = 0; ei = 0;
        if (m_over) return;
        eff = (d == (m_dir ^ 2)) ? m_dir : d;
        m_dir = eff;
        nx = mx[0]; ny = my[0];
        case (eff)
            0: ny--;
            1: nx++;
            2: ny++;
            default: nx--;
        endcase
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            m_over = 1; eb = 1; return;
        end
        fi = -1;
        for (int i = 0; i < FN; i++)
            if (fi < 0 && fv[i] && fx[i] == nx && fy[i] == ny) fi = i;
        grow = (fi >= 0);
        len = mx.size();
        for (int k = 0; k < len; k++) begin
            if (k == len - 1 && !grow) continue;
            if (mx[k] == nx && my[k] == ny) begin
                m_over = 1; eb = 2 + k; return;
            end
        end
        eb = len + 2;
        mx.push_front(nx); my.push_front(ny);
        if (!grow || len == MAXL) begin
            void'(mx.pop_back());
            void'(my.pop_back());
        end
        if (grow) begin ea = 1; ei = fi; end
    endtask

    task automatic apply_reset();
        mon_en = 0;
        @(negedge draw_clk);
        reset_n = 0;
        repeat (2) @(posedge draw_clk);
        #1;
        model_reset();
        reset_n = 1;
        mon_en = 1;
    endtask

    task automatic do_step(input int d);
        int eb, ea, ei, bc, ac, ai;
        @(posedge draw_clk); #1;
        step = 1; direction = 2'(d);
        @(posedge draw_clk); #1;
        step = 0;
        model_step(d, eb, ea, ei);
        bc = 0; ac = 0; ai = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge draw_clk);
            if (ate) begin ac++; ai = int'(ate_idx); end
            if (!busy) break;
            bc++;
        end
        chk("busy_cycles", bc, eb);
        chk("ate_pulses", ac, ea);
        if (ea != 0) chk("ate_idx", ai, ei);
        last_bc = bc; last_ac = ac; last_ai = ai;
    endtask

    task automatic add_cell(input int cx, input int cy, input int k,
                            inout int ex[$], inout int ey[$], inout int ek[$]);
        for (int sy = 0; sy < C; sy++)
            for (int sx = 0; sx < C; sx++) begin
                ex.push_back(cx * C + sx);
                ey.push_back(cy * C + sy);
                ek.push_back(k);
            end
    endtask

    task automatic do_draw(input int rdy_pct, input bit pin);
        int ex[$], ey[$], ek[$];
        int total, n, dcnt, px, py, pk, limit;
        int p0x, p0y, p0k, p1x, p1k, p3x, p3y, p3k;
        bit last_hs, pv, pr;
        for (int s = 0; s < mx.size(); s++) add_cell(mx[s], my[s], (s == 0) ? 0 : 1, ex, ey, ek);
        for (int i = 0; i < FN; i++) if (fv[i]) add_cell(fx[i], fy[i], 2, ex, ey, ek);
        total = ex.size();
        limit = total * 8 + 64;
        n = 0; dcnt = 0; last_hs = 0; pv = 0; pr = 0; px = 0; py = 0; pk = 0;
        p0x = -1; p0y = -1; p0k = -1; p1x = -1; p1k = -1; p3x = -1; p3y = -1; p3k = -1;
        @(posedge draw_clk); #1;
        draw_start = 1;
        @(posedge draw_clk); #1;
        draw_start = 0;
        pix_ready = ($urandom_range(99) < rdy_pct);
        for (int c = 0; c < limit; c++) begin
            @(negedge draw_clk);
            chk("draw_done_timing", int'(draw_done), int'(last_hs));
            if (draw_done) dcnt++;
            if (pv && !pr) begin
                chk("hold_valid", int'(pix_valid), 1);
                chk("hold_x", int'(pix_x), px);
                chk("hold_y", int'(pix_y), py);
                chk("hold_kind", int'(pix_kind), pk);
            end
            last_hs = 0;
            if (pix_valid) begin
                if (n < total) begin
                    chk("pix_x", int'(pix_x), ex[n]);
                    chk("pix_y", int'(pix_y), ey[n]);
                    chk("pix_kind", int'(pix_kind), ek[n]);
                end else begin
                    chk("extra_pixel", n, total - 1);
                end
                if (pix_ready) begin
                    if (n == 0)   begin p0x = int'(pix_x); p0y = int'(pix_y); p0k = int'(pix_kind); end
                    if (n == 100) begin p1x = int'(pix_x); p1k = int'(pix_kind); end
                    if (n == 300) begin p3x = int'(pix_x); p3y = int'(pix_y); p3k = int'(pix_kind); end
                    n++;
                    last_hs = (n == total);
                end
            end
            pv = pix_valid; pr = pix_ready;
            px = int'(pix_x); py = int'(pix_y); pk = int'(pix_kind);
            if (dcnt != 0) break;
            @(posedge draw_clk); #1;
            pix_ready = ($urandom_range(99) < rdy_pct);
        end
        chk("draw_done_pulses", dcnt, 1);
        chk("handshakes", n, total);
        @(negedge draw_clk);
        chk("after_done_quiet", int'(draw_done) + int'(pix_valid), 0);
        if (pin) begin
            chk("lit_total", n, 400);
            chk("lit_first_x", p0x, 320);
            chk("lit_first_y", p0y, 240);
            chk("lit_first_kind", p0k, 0);
            chk("lit_seg1_x", p1x, 310);
            chk("lit_seg1_kind", p1k, 1);
            chk("lit_food_x", p3x, 100);
            chk("lit_food_y", p3y, 100);
            chk("lit_food_kind", p3k, 2);
        end
        pix_ready = 0;
    endtask

    task automatic rand_food(input int d);
        int k, nx, ny;
        clear_food();
        for (int i = 0; i < FN; i++)
            if ($urandom_range(3) == 0) begin
                fv[i] = 1;
                fx[i] = mx[0] + $urandom_range(4) - 2;
                fy[i] = my[0] + $urandom_range(4) - 2;
                if (fx[i] < 0) fx[i] = 0;
                if (fx[i] > GW - 1) fx[i] = GW - 1;
                if (fy[i] < 0) fy[i] = 0;
                if (fy[i] > GH - 1) fy[i] = GH - 1;
            end
        if ($urandom_range(1) == 0) begin
            nx = mx[0] + ((d == 1) ? 1 : (d == 3) ? -1 : 0);
            ny = my[0] + ((d == 2) ? 1 : (d == 0) ? -1 : 0);
            if (nx >= 0 && nx < GW && ny >= 0 && ny < GH) begin
                k = $urandom_range(FN - 1);
                fv[k] = 1; fx[k] = nx; fy[k] = ny;
            end
        end
    endtask

    // Idle-cycle comparison of architectural outputs against the model
    always @(negedge draw_clk) begin
        if (mon_en && reset_n && !busy) begin
            chk("mon_head_cx", int'(head_cx), mx[0]);
            chk("mon_head_cy", int'(head_cy), my[0]);
            chk("mon_length", int'(length), mx.size());
            chk("mon_game_over", int'(game_over), int'(m_over));
            chk("mon_idle_quiet", int'(pix_valid) + int'(ate) + int'(draw_done), 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, dn;
        clear_food();
        model_reset();
        repeat (2) @(posedge draw_clk);
        #1;
        chk("rst_head_cx", int'(head_cx), 32);
        chk("rst_head_cy", int'(head_cy), 24);
        chk("rst_length", int'(length), 3);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pix_valid", int'(pix_valid), 0);
        chk("rst_outputs", int'(ate) + int'(game_over) + int'(draw_done) + int'(ate_idx), 0);
        reset_n = 1;
        mon_en = 1;

        fv[2] = 1; fx[2] = 10; fy[2] = 10;
        do_draw(50, 1);
        clear_food();

        do_step(1);
        chk("s1_head_cx", int'(head_cx), 33);
        chk("s1_busy_cycles", last_bc, 5);
        chk("s1_no_ate", last_ac, 0);

        fv[4] = 1; fx[4] = 34; fy[4] = 24;
        fv[6] = 1; fx[6] = 34; fy[6] = 24;
        do_step(1);
        chk("grow_idx", last_ai, 4);
        chk("grow_len", int'(length), 4);
        clear_food();
        do_step(3);
        chk("reverse_head_cx", int'(head_cx), 35);

        do_step(0); do_step(3); do_step(2); do_step(1);
        chk("chase_no_over", int'(game_over), 0);
        chk("chase_head_cx", int'(head_cx), 35);

        fv[0] = 1; fx[0] = 36; fy[0] = 24;
        do_step(1);
        chk("len5", int'(length), 5);
        clear_food();
        do_step(0); do_step(3); do_step(2);
        chk("loop_over", int'(game_over), 1);
        chk("loop_busy", last_bc, 5);
        chk("loop_head_cy", int'(head_cy), 23);
        do_step(1);
        chk("over_step_ignored", last_bc, 0);
        do_draw(60, 0);

        apply_reset();
        for (int i = 0; i < 31; i++) do_step(1);
        chk("edge_head_cx", int'(head_cx), 63);
        do_step(1);
        chk("wall_over", int'(game_over), 1);
        chk("wall_busy", last_bc, 1);
        chk("wall_head_cx", int'(head_cx), 63);
        do_step(1);
        chk("wall_step_ignored", last_bc, 0);

        apply_reset();
        for (int i = 0; i < 14; i++) begin
            clear_food();
            fv[i % FN] = 1; fx[i % FN] = mx[0] + 1; fy[i % FN] = 24;
            do_step(1);
        end
        chk("sat_len", int'(length), 16);
        chk("sat_head_cx", int'(head_cx), 46);
        clear_food();
        fv[3] = 1; fx[3] = 5; fy[3] = 5;
        do_draw(75, 0);
        clear_food();
        do_step(0); do_step(3); do_step(2);
        chk("sat_loop_over", int'(game_over), 1);

        apply_reset();
        do_step(1); do_step(0);
        @(posedge draw_clk); #1;
        draw_start = 1;
        @(posedge draw_clk); #1;
        draw_start = 0; pix_ready = 1;
        repeat (20) @(posedge draw_clk);
        #2;
        mon_en = 0;
        reset_n = 0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_pix_valid", int'(pix_valid), 0);
        chk("abort_head_cx", int'(head_cx), 32);
        chk("abort_head_cy", int'(head_cy), 24);
        dn = 0;
        repeat (3) begin
            @(negedge draw_clk);
            if (draw_done) dn++;
        end
        chk("abort_no_done", dn, 0);
        pix_ready = 0;
        @(posedge draw_clk); #1;
        model_reset();
        reset_n = 1;
        mon_en = 1;

        for (int it = 0; it < 120; it++) begin
            if (m_over) apply_reset();
            d = ($urandom_range(9) < 6) ? m_dir : int'($urandom_range(3));
            rand_food(d);
            if ($urandom_range(7) == 0) do_draw(75, 0);
            else                        do_step(d);
        end

        @(negedge draw_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
